// File: rtl/riscv_pkg.sv
// Shared RV32I constants, the MEM-stage state type, and the byte-lane helpers
// used by the memory access stage.
package riscv_pkg;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {IDLE, ACCESS} mem_state_e;

  // Unknown size encodings report as not-ok so they retire as a nop with an error.
  function automatic logic access_ok(input logic is_store, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_LB:  ok = 1'b1;
      F3_LH:  ok = ~addr_lo[0];
      F3_LW:  ok = (addr_lo == 2'b00);
      F3_LBU: ok = ~is_store;
      F3_LHU: ok = ~is_store & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = 4'b0011 << addr_lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/memory_access_stage_load_formatter.sv
// Load data formatter: picks the addressed byte/half out of the raw read word
// and sign- or zero-extends it to XLEN.
module load_formatter
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] lmd
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   lmd = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   lmd = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  lmd = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  lmd = {{(XLEN-16){1'b0}}, half_sel};
      default: lmd = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// RV32I MEM stage: issues loads/stores over a req/ack data-memory handshake,
// stalls upstream while waiting, and registers the MEM/WB bundle.
module memory_access_stage
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_funct3,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_rs2_data,
  output logic            mem_stall,
  output logic            mem_err,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [6:0]      wb_opcode,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_write,
  output logic [XLEN-1:0] wb_alu_result,
  output logic [XLEN-1:0] wb_lmd
);

  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  mem_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;

  logic            wb_valid_reg, wb_valid_next;
  logic [6:0]      wb_opcode_reg, wb_opcode_next;
  logic [4:0]      wb_rd_reg, wb_rd_next;
  logic            wb_rw_reg, wb_rw_next;
  logic [XLEN-1:0] wb_alu_reg, wb_alu_next;
  logic [XLEN-1:0] wb_lmd_reg, wb_lmd_next;

  // Access captured on the first request cycle; drives the bus while in ACCESS.
  logic            capture;
  logic            acc_we_reg;
  logic [2:0]      acc_f3_reg;
  logic [3:0]      acc_be_reg;
  logic [XLEN-1:0] acc_wdata_reg;
  logic [6:0]      acc_opcode_reg;
  logic [4:0]      acc_rd_reg;
  logic            acc_rw_reg;
  logic [XLEN-1:0] acc_alu_reg;

  logic            is_load, is_store, ok, rd_write;
  logic [3:0]      ex_be;
  logic [XLEN-1:0] ex_wdata;
  logic [2:0]      fmt_f3;
  logic [1:0]      fmt_addr;
  logic [XLEN-1:0] fmt_lmd;

  load_formatter #(.XLEN(XLEN)) u_fmt (
    .funct3  (fmt_f3),
    .addr_lo (fmt_addr),
    .rdata   (dmem_rdata),
    .lmd     (fmt_lmd)
  );

  always_comb begin
    is_load  = (ex_opcode == OPCODE_LOAD);
    is_store = (ex_opcode == OPCODE_STORE);
    ok       = access_ok(is_store, ex_funct3, ex_alu_result[1:0]);
    rd_write = ex_reg_write & (ex_rd != 5'd0) & ~is_store;
    ex_be    = lane_be(ex_funct3, ex_alu_result[1:0]);
    case (ex_funct3[1:0])
      2'b00:   ex_wdata = {(XLEN/8){ex_rs2_data[7:0]}};
      2'b01:   ex_wdata = {(XLEN/16){ex_rs2_data[15:0]}};
      default: ex_wdata = ex_rs2_data;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    err_next       = 1'b0;
    capture        = 1'b0;
    wb_valid_next  = 1'b0;
    wb_opcode_next = wb_opcode_reg;
    wb_rd_next     = wb_rd_reg;
    wb_rw_next     = wb_rw_reg;
    wb_alu_next    = wb_alu_reg;
    wb_lmd_next    = wb_lmd_reg;
    mem_stall      = 1'b0;
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    dmem_addr      = '0;
    dmem_be        = 4'b0000;
    dmem_wdata     = '0;
    fmt_f3         = ex_funct3;
    fmt_addr       = ex_alu_result[1:0];

    case (state_reg)
      IDLE: begin
        if (ex_valid) begin
          if ((is_load || is_store) && ok) begin
            dmem_req   = 1'b1;
            dmem_we    = is_store;
            dmem_addr  = {ex_alu_result[XLEN-1:2], 2'b00};
            dmem_be    = ex_be;
            dmem_wdata = is_store ? ex_wdata : '0;
          end
          if ((is_load || is_store) && ok && !dmem_ack) begin
            mem_stall  = 1'b1;
            capture    = 1'b1;
            cnt_next   = CNT_W'(1);
            state_next = ACCESS;
          end else begin
            wb_valid_next  = 1'b1;
            wb_opcode_next = ex_opcode;
            wb_rd_next     = ex_rd;
            wb_alu_next    = ex_alu_result;
            wb_rw_next     = rd_write;
            wb_lmd_next    = (is_load && ok) ? fmt_lmd : '0;
            if ((is_load || is_store) && !ok) begin
              wb_rw_next = 1'b0;
              err_next   = 1'b1;
            end
          end
        end
      end
      ACCESS: begin
        fmt_f3     = acc_f3_reg;
        fmt_addr   = acc_alu_reg[1:0];
        dmem_req   = 1'b1;
        dmem_we    = acc_we_reg;
        dmem_addr  = {acc_alu_reg[XLEN-1:2], 2'b00};
        dmem_be    = acc_be_reg;
        dmem_wdata = acc_wdata_reg;
        if (dmem_ack || cnt_reg >= CNT_W'(ACK_TIMEOUT - 1)) begin
          wb_valid_next  = 1'b1;
          wb_opcode_next = acc_opcode_reg;
          wb_rd_next     = acc_rd_reg;
          wb_alu_next    = acc_alu_reg;
          wb_rw_next     = dmem_ack & acc_rw_reg;
          wb_lmd_next    = (dmem_ack && !acc_we_reg) ? fmt_lmd : '0;
          err_next       = ~dmem_ack;
          state_next     = IDLE;
        end else begin
          mem_stall = 1'b1;
          cnt_next  = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Bus and stall stay quiet for the whole reset window, even mid-access.
    if (!rst_n) begin
      mem_stall  = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_be    = 4'b0000;
      dmem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      err_reg        <= 1'b0;
      wb_valid_reg   <= 1'b0;
      wb_opcode_reg  <= '0;
      wb_rd_reg      <= '0;
      wb_rw_reg      <= 1'b0;
      wb_alu_reg     <= '0;
      wb_lmd_reg     <= '0;
      acc_we_reg     <= 1'b0;
      acc_f3_reg     <= '0;
      acc_be_reg     <= '0;
      acc_wdata_reg  <= '0;
      acc_opcode_reg <= '0;
      acc_rd_reg     <= '0;
      acc_rw_reg     <= 1'b0;
      acc_alu_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      err_reg       <= err_next;
      wb_valid_reg  <= wb_valid_next;
      wb_opcode_reg <= wb_opcode_next;
      wb_rd_reg     <= wb_rd_next;
      wb_rw_reg     <= wb_rw_next;
      wb_alu_reg    <= wb_alu_next;
      wb_lmd_reg    <= wb_lmd_next;
      if (capture) begin
        acc_we_reg     <= is_store;
        acc_f3_reg     <= ex_funct3;
        acc_be_reg     <= ex_be;
        acc_wdata_reg  <= is_store ? ex_wdata : '0;
        acc_opcode_reg <= ex_opcode;
        acc_rd_reg     <= ex_rd;
        acc_rw_reg     <= rd_write;
        acc_alu_reg    <= ex_alu_result;
      end
    end
  end

  assign mem_err       = err_reg;
  assign wb_valid      = wb_valid_reg;
  assign wb_opcode     = wb_opcode_reg;
  assign wb_rd         = wb_rd_reg;
  assign wb_reg_write  = wb_rw_reg;
  assign wb_alu_result = wb_alu_reg;
  assign wb_lmd        = wb_lmd_reg;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: loads, stores, ALU pass-through,
// misalignment, ack timeout and mid-access reset, with hand-computed expectations.
module tb_memory_access_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_rs2_data;
  logic        mem_stall, mem_err, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_reg_write;
  logic [6:0]  wb_opcode;
  logic [4:0]  wb_rd;
  logic [31:0] wb_alu_result, wb_lmd;

  int n_cmp = 0;
  int n_bad = 0;

  memory_access_stage #(.XLEN(32), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
    .mem_stall(mem_stall), .mem_err(mem_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_opcode(wb_opcode), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_alu_result(wb_alu_result), .wb_lmd(wb_lmd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] rd, input logic rw, input logic [31:0] alu,
                        input logic [31:0] rs2);
    ex_valid = v; ex_opcode = op; ex_funct3 = f3; ex_rd = rd;
    ex_reg_write = rw; ex_alu_result = alu; ex_rs2_data = rs2;
  endtask

  // Runs one memory access with ack raised on request cycle ack_at (0 = same cycle).
  // Captures bus outputs of the first request cycle and counts stalled cycles.
  task automatic do_access(input string name, input int ack_at, input logic [31:0] rdata,
                           output int stalls, output logic req0, output logic we0,
                           output logic [3:0] be0, output logic [31:0] addr0,
                           output logic [31:0] wdata0);
    stalls = 0; req0 = 0; we0 = 0; be0 = 0; addr0 = 0; wdata0 = 0;
    for (int c = 0; c <= ack_at; c++) begin
      if (c == ack_at) begin
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
      end
      #1;
      if (mem_stall) stalls++;
      if (c == 0) begin
        req0 = dmem_req; we0 = dmem_we; be0 = dmem_be; addr0 = dmem_addr; wdata0 = dmem_wdata;
      end
      tick();
    end
    dmem_ack = 1'b0;
    ex_valid = 1'b0;
    $display("txn %s: stalls=%0d be=%b we=%b wdata=%h wb_lmd=%h wb_rw=%b",
             name, stalls, be0, we0, wdata0, wb_lmd, wb_reg_write);
  endtask

  int          st;
  logic        r0, w0;
  logic [3:0]  b0;
  logic [31:0] a0, d0;
  int          req_cycles;

  initial begin
    rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    set_ex(0, 7'd0, 3'd0, 5'd0, 0, 32'd0, 32'd0);
    tick(); tick();
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_err", {31'd0, mem_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU op passes through with one cycle latency
    set_ex(1, OP_ALU, 3'd0, 5'd5, 1, 32'd42, 32'd0);
    #1;
    check("add_stall", {31'd0, mem_stall}, 32'd0);
    check("add_req", {31'd0, dmem_req}, 32'd0);
    tick();
    $display("txn ADD rd=5: wb_alu=%0d wb_rd=%0d wb_rw=%b", wb_alu_result, wb_rd, wb_reg_write);
    check("add_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("add_wb_alu", wb_alu_result, 32'd42);
    check("add_wb_rd", {27'd0, wb_rd}, 32'd5);
    check("add_wb_rw", {31'd0, wb_reg_write}, 32'd1);
    check("add_wb_lmd", wb_lmd, 32'd0);
    set_ex(1, OP_ALU, 3'd0, 5'd0, 1, 32'd7, 32'd0);
    tick();
    $display("txn ADD rd=0: wb_rw=%b", wb_reg_write);
    check("add_rd0_rw", {31'd0, wb_reg_write}, 32'd0);
    ex_valid = 1'b0;
    tick();
    $display("txn bubble: wb_valid=%b wb_alu=%0d", wb_valid, wb_alu_result);
    check("bubble_valid", {31'd0, wb_valid}, 32'd0);
    check("bubble_hold", wb_alu_result, 32'd7);

    // LW with ack on the 4th request cycle
    set_ex(1, OP_LOAD, 3'b010, 5'd7, 1, 32'h100, 32'd0);
    do_access("LW 0x100", 3, 32'hDEADBEEF, st, r0, w0, b0, a0, d0);
    check("lw_stalls", st, 32'd3);
    check("lw_req", {31'd0, r0}, 32'd1);
    check("lw_we", {31'd0, w0}, 32'd0);
    check("lw_be", {28'd0, b0}, 32'hF);
    check("lw_addr", a0, 32'h100);
    check("lw_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("lw_wb_lmd", wb_lmd, 32'hDEADBEEF);
    check("lw_wb_rd", {27'd0, wb_rd}, 32'd7);

    // LB with same-cycle ack, LBU with ack one cycle later
    set_ex(1, OP_LOAD, 3'b000, 5'd3, 1, 32'h103, 32'd0);
    do_access("LB 0x103", 0, 32'h80FFFFFF, st, r0, w0, b0, a0, d0);
    check("lb_stalls", st, 32'd0);
    check("lb_be", {28'd0, b0}, 32'b1000);
    check("lb_addr", a0, 32'h100);
    check("lb_lmd", wb_lmd, 32'hFFFFFF80);
    set_ex(1, OP_LOAD, 3'b100, 5'd3, 1, 32'h103, 32'd0);
    do_access("LBU 0x103", 1, 32'h80FFFFFF, st, r0, w0, b0, a0, d0);
    check("lbu_stalls", st, 32'd1);
    check("lbu_lmd", wb_lmd, 32'h00000080);

    // Halfword loads from the upper lane
    set_ex(1, OP_LOAD, 3'b001, 5'd4, 1, 32'h102, 32'd0);
    do_access("LH 0x102", 1, 32'h80010000, st, r0, w0, b0, a0, d0);
    check("lh_be", {28'd0, b0}, 32'b1100);
    check("lh_lmd", wb_lmd, 32'hFFFF8001);
    set_ex(1, OP_LOAD, 3'b101, 5'd4, 1, 32'h102, 32'd0);
    do_access("LHU 0x102", 2, 32'h80010000, st, r0, w0, b0, a0, d0);
    check("lhu_lmd", wb_lmd, 32'h00008001);

    // Stores
    set_ex(1, OP_STORE, 3'b001, 5'd9, 1, 32'h202, 32'h1234ABCD);
    do_access("SH 0x202", 2, 32'd0, st, r0, w0, b0, a0, d0);
    check("sh_be", {28'd0, b0}, 32'b1100);
    check("sh_wdata", d0, 32'hABCDABCD);
    check("sh_we", {31'd0, w0}, 32'd1);
    check("sh_addr", a0, 32'h200);
    check("sh_stalls", st, 32'd2);
    check("sh_wb_rw", {31'd0, wb_reg_write}, 32'd0);
    check("sh_wb_valid", {31'd0, wb_valid}, 32'd1);
    set_ex(1, OP_STORE, 3'b000, 5'd0, 0, 32'h101, 32'h00000055);
    do_access("SB 0x101", 0, 32'd0, st, r0, w0, b0, a0, d0);
    check("sb_be", {28'd0, b0}, 32'b0010);
    check("sb_wdata", d0, 32'h55555555);

    // Misaligned word load and unknown funct3 both retire as nop with error
    set_ex(1, OP_LOAD, 3'b010, 5'd6, 1, 32'h101, 32'd0);
    #1;
    check("mis_req", {31'd0, dmem_req}, 32'd0);
    check("mis_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    ex_valid = 1'b0;
    $display("txn LW 0x101: mem_err=%b wb_valid=%b wb_rw=%b", mem_err, wb_valid, wb_reg_write);
    check("mis_err", {31'd0, mem_err}, 32'd1);
    check("mis_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("mis_wb_rw", {31'd0, wb_reg_write}, 32'd0);
    tick();
    check("mis_err_pulse", {31'd0, mem_err}, 32'd0);
    set_ex(1, OP_LOAD, 3'b011, 5'd6, 1, 32'h100, 32'd0);
    #1;
    check("f3bad_req", {31'd0, dmem_req}, 32'd0);
    tick();
    ex_valid = 1'b0;
    $display("txn LOAD f3=3: mem_err=%b", mem_err);
    check("f3bad_err", {31'd0, mem_err}, 32'd1);
    tick();

    // Ack timeout: 16 request cycles, then error and request dropped
    set_ex(1, OP_LOAD, 3'b010, 5'd8, 1, 32'h300, 32'd0);
    req_cycles = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (dmem_req) req_cycles++;
      tick();
    end
    ex_valid = 1'b0;
    #1;
    $display("txn LW timeout: req_cycles=%0d mem_err=%b", req_cycles, mem_err);
    check("to_req_cycles", req_cycles, 32'd16);
    check("to_err", {31'd0, mem_err}, 32'd1);
    check("to_req_drop", {31'd0, dmem_req}, 32'd0);
    check("to_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("to_wb_rw", {31'd0, wb_reg_write}, 32'd0);
    tick();

    // Reset while an access is outstanding
    set_ex(1, OP_LOAD, 3'b010, 5'd2, 1, 32'h100, 32'd0);
    tick(); tick();
    check("rr_req_before", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    ex_valid = 1'b0;
    tick();
    $display("txn reset mid-access: req=%b stall=%b wb_valid=%b", dmem_req, mem_stall, wb_valid);
    check("rr_req", {31'd0, dmem_req}, 32'd0);
    check("rr_stall", {31'd0, mem_stall}, 32'd0);
    check("rr_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rr_wb_alu", wb_alu_result, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rr_idle_req", {31'd0, dmem_req}, 32'd0);

    // Stage must be back in IDLE: a fresh LW completes normally
    set_ex(1, OP_LOAD, 3'b010, 5'd1, 1, 32'h104, 32'd0);
    do_access("LW 0x104", 1, 32'h13572468, st, r0, w0, b0, a0, d0);
    check("post_rst_lmd", wb_lmd, 32'h13572468);
    check("post_rst_addr", a0, 32'h104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
